mem_access_unit: RTL and testbench

MEM-stage load/store controller between the EX/MEM pipeline register and the MEM/WB register.
- Turns EX/MEM control and ALU result into a req/ack data-memory transaction with byte-lane formatting.
- Stalls the pipeline while a transaction is outstanding.
- Delivers aligned, sign/zero-extended load data, or passes the ALU result through, to writeback.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_access_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
//============================================================================
// Module   : mem_pkg
// Summary  : Shared types and helpers for the MEM-stage load/store unit:
//            size encodings, FSM state enum, byte-lane helper functions
//            and the default transaction timeout.
// Revision : 1.0 - initial release
//============================================================================
package mem_pkg;

    // Access size encodings; 2'b11 is handled as a word everywhere
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Default abort threshold in cycles when the timeout option is built in
    localparam int c_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DRAIN = 2'b10
    } mem_state_t;

    // Little-endian byte enables for an access of size sz at byte offset off
    function automatic logic [3:0] f_byte_en(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Byte always aligned, half needs even address, word needs addr[1:0]==0
    function automatic logic f_aligned(input logic [1:0] sz, input logic [1:0] off);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    // Replicate the significant store bits across all lanes so the byte
    // enables alone select what the memory writes
    function automatic logic [31:0] f_lane_data(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        case (sz)
            SZ_BYTE: d = {4{wd[7:0]}};
            SZ_HALF: d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
//============================================================================
// Module   : mem_load_align
// Summary  : Combinational load formatter. Shifts the addressed lane of the
//            read word down to bit 0 and sign/zero-extends sub-word loads.
// Revision : 1.0 - initial release
//============================================================================
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    // Bring the addressed byte/half to the bottom and extend it
    always_comb begin
        w_shift = i_rdata >> {i_offset, 3'b000};
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sign_ext & w_shift[7]}},  w_shift[7:0]};
            SZ_HALF: o_data = {{16{i_sign_ext & w_shift[15]}}, w_shift[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
//============================================================================
// Module   : mem_access_unit
// Summary  : MEM-stage load/store controller. Issues req/ack data-memory
//            transactions with byte-lane formatting, stalls the pipeline
//            while one is outstanding and drives the MEM/WB results.
// Options  : MEM_TIMEOUT_EN - abort a transaction after TIMEOUT cycles
//            without dm_ack and pulse mem_err.
// Revision : 1.0 - initial release
//============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [3:0]  reg_dst_in,
    input  logic        reg_wr_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_reg_dst,
    output logic        wb_reg_wr,
    output logic        misalign,
    output logic        mem_err
);

    mem_state_t  r_state;
    mem_state_t  w_state_nxt;
    logic        w_stall;
    logic        w_mem_op;
    logic        w_aligned;
    logic        w_new_op;
    logic        w_misalign;
    logic        w_timeout;
    logic [31:0] w_fmt;

    // Latched request fields, held stable for the whole transaction
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [3:0]  r_dst;
    logic        r_rwr;

    // Writeback / pulse registers
    logic [31:0] r_wb_data;
    logic [3:0]  r_wb_dst;
    logic        r_wb_wr;
    logic        r_misalign;

    assign w_mem_op   = mem_rd | mem_wr;
    assign w_aligned  = f_aligned(size, addr[1:0]);
    assign w_new_op   = w_mem_op & w_aligned & ~flush;
    assign w_misalign = w_mem_op & ~w_aligned & ~flush;

`ifdef MEM_TIMEOUT_EN
    localparam int             c_CW   = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_cnt;
    logic            r_mem_err;

    // Abort on the TIMEOUT-th outstanding cycle if the memory still has not acked
    assign w_timeout = (r_state != ST_IDLE) & ~dm_ack & (r_cnt == c_TMAX);

    // Count cycles spent in WAIT/DRAIN; cleared whenever the FSM returns to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_timeout;
            if ((r_state != ST_IDLE) && (w_state_nxt != ST_IDLE))
                r_cnt <= r_cnt + c_ONE;
            else
                r_cnt <= '0;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and stall; DRAIN stays stalled on its ack so the op held
    // upstream is taken in IDLE on the following cycle
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_new_op) begin
                    w_state_nxt = ST_WAIT;
                    w_stall     = 1'b1;
                end
            end
            ST_WAIT: begin
                w_stall = ~dm_ack & ~w_timeout;
                if (dm_ack || w_timeout)
                    w_state_nxt = ST_IDLE;
                else if (flush)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_stall = ~w_timeout;
                if (dm_ack || w_timeout)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture request fields when a new aligned memory op is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_sign  <= 1'b0;
            r_dst   <= '0;
            r_rwr   <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_new_op) begin
            r_we    <= mem_wr;
            r_addr  <= {addr[31:2], 2'b00};
            r_be    <= f_byte_en(size, addr[1:0]);
            r_wdata <= f_lane_data(size, wdata);
            r_off   <= addr[1:0];
            r_size  <= size;
            r_sign  <= sign_ext;
            r_dst   <= reg_dst_in;
            r_rwr   <= reg_wr_in & ~mem_wr;
        end
    end

    mem_load_align u_load_align (
        .i_rdata    (dm_rdata),
        .i_offset   (r_off),
        .i_size     (r_size),
        .i_sign_ext (r_sign),
        .o_data     (w_fmt)
    );

    // Writeback register: pass-through for non-memory ops, formatted data on
    // a completed unflushed load, bubble otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_data  <= '0;
            r_wb_dst   <= '0;
            r_wb_wr    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_wb_wr    <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!flush && !w_mem_op) begin
                        r_wb_data <= addr;
                        r_wb_dst  <= reg_dst_in;
                        r_wb_wr   <= reg_wr_in;
                    end else if (w_misalign) begin
                        r_misalign <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dm_ack && !flush && !r_we) begin
                        r_wb_data <= w_fmt;
                        r_wb_dst  <= r_dst;
                        r_wb_wr   <= r_rwr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm_req     = (r_state != ST_IDLE);
    assign dm_we      = r_we;
    assign dm_addr    = r_addr;
    assign dm_be      = r_be;
    assign dm_wdata   = r_wdata;
    // Gated by reset so every output reads 0 while reset is held
    assign mem_stall  = w_stall & rst_n;
    assign wb_data    = r_wb_data;
    assign wb_reg_dst = r_wb_dst;
    assign wb_reg_wr  = r_wb_wr;
    assign misalign   = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_mem_access_unit
// Summary  : Scoreboard bench for mem_access_unit. Directed ops push the
//            expected memory request / writeback; a negedge monitor pops
//            and compares whenever the DUT completes one.
// Revision : 1.0 - initial release
//============================================================================
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, mem_rd, mem_wr, sign_ext, reg_wr_in, dm_ack;
    logic [31:0] addr, wdata, dm_rdata;
    logic [1:0]  size;
    logic [3:0]  reg_dst_in;
    logic        dm_req, dm_we, mem_stall, wb_reg_wr, misalign, mem_err;
    logic [31:0] dm_addr, dm_wdata, wb_data;
    logic [3:0]  dm_be, wb_reg_dst;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .addr(addr), .wdata(wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size), .sign_ext(sign_ext),
        .reg_dst_in(reg_dst_in), .reg_wr_in(reg_wr_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .wb_data(wb_data), .wb_reg_dst(wb_reg_dst),
        .wb_reg_wr(wb_reg_wr), .misalign(misalign), .mem_err(mem_err)
    );

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] data; logic [3:0] dst; } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   mis_pending = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    req_t mon_r;
    wb_t  mon_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each completed transaction, writeback and misalign pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (dm_req && dm_ack) begin
                if (req_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
                else begin
                    mon_r = req_q.pop_front();
                    chk("req_we",   {31'd0, dm_we}, {31'd0, mon_r.we});
                    chk("req_addr", dm_addr, mon_r.addr);
                    chk("req_be",   {28'd0, dm_be}, {28'd0, mon_r.be});
                    if (mon_r.we) chk("req_wdata", dm_wdata, mon_r.wdata);
                end
            end
            if (wb_reg_wr) begin
                if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
                else begin
                    mon_w = wb_q.pop_front();
                    chk("wb_data", wb_data, mon_w.data);
                    chk("wb_dst",  {28'd0, wb_reg_dst}, {28'd0, mon_w.dst});
                end
            end
            if (misalign) begin
                chk("misalign_expected", (mis_pending > 0) ? 32'd1 : 32'd0, 32'd1);
                if (mis_pending > 0) mis_pending--;
            end
        end
    end

    task automatic bubble();
        mem_rd = 1'b0; mem_wr = 1'b0; flush = 1'b0; reg_wr_in = 1'b0;
        addr = '0; wdata = '0; size = '0; sign_ext = 1'b0; reg_dst_in = '0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] dst,
                          input logic rw);
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
        reg_dst_in = dst; reg_wr_in = rw; flush = 1'b0;
    endtask

    // Op already applied (cycle 0); ack 'delay' cycles after dm_req rises
    task automatic run_mem(input int delay, input logic [31:0] rd, input int exp_stalls,
                           input logic exp_wr);
        int stalls = 0;
        @(negedge clk);
        if (mem_stall) stalls++;
        chk("req_cycle0", {31'd0, dm_req}, 32'd0);
        for (int k = 0; k <= delay; k++) begin
            @(posedge clk); #1;
            if (k == delay) begin dm_ack = 1'b1; dm_rdata = rd; end
            @(negedge clk);
            chk("req_held", {31'd0, dm_req}, 32'd1);
            if (mem_stall) stalls++;
        end
        @(posedge clk); #1;
        dm_ack = 1'b0;
        bubble();
        @(negedge clk);
        chk("stall_cycles", stalls, exp_stalls);
        chk("wb_wr_latency", {31'd0, wb_reg_wr}, {31'd0, exp_wr});
    endtask

    initial begin
        int cnt;
        bubble();
        dm_ack = 1'b0; dm_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {20'd0, dm_req, dm_we, dm_be, wb_reg_dst, wb_reg_wr, misalign, mem_err, mem_stall}, 32'd0);
        chk("reset_data", dm_addr | dm_wdata | wb_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Word load, ack 3 cycles after request
        set_op(1, 0, SZ_WORD, 0, 32'h100, 0, 4'd5, 1);
        req_q.push_back('{1'b0, 32'h100, 4'b1111, 32'h0});
        wb_q.push_back('{32'hDEADBEEF, 4'd5});
        run_mem(3, 32'hDEADBEEF, 4, 1'b1);

        // Signed byte, earliest timing
        set_op(1, 0, SZ_BYTE, 1, 32'h103, 0, 4'd6, 1);
        req_q.push_back('{1'b0, 32'h100, 4'b1000, 32'h0});
        wb_q.push_back('{32'hFFFFFF80, 4'd6});
        run_mem(0, 32'h80112233, 1, 1'b1);

        // Unsigned half at upper lane
        set_op(1, 0, SZ_HALF, 0, 32'h102, 0, 4'd7, 1);
        req_q.push_back('{1'b0, 32'h100, 4'b1100, 32'h0});
        wb_q.push_back('{32'h00008011, 4'd7});
        run_mem(1, 32'h80112233, 2, 1'b1);

        // Signed half at lower lane
        set_op(1, 0, SZ_HALF, 1, 32'h100, 0, 4'd8, 1);
        req_q.push_back('{1'b0, 32'h100, 4'b0011, 32'h0});
        wb_q.push_back('{32'hFFFFF00D, 4'd8});
        run_mem(0, 32'h1234F00D, 1, 1'b1);

        // Unsigned byte with top bit set stays zero-extended
        set_op(1, 0, SZ_BYTE, 0, 32'h101, 0, 4'd9, 1);
        req_q.push_back('{1'b0, 32'h100, 4'b0010, 32'h0});
        wb_q.push_back('{32'h000000F1, 4'd9});
        run_mem(0, 32'h0000F100, 1, 1'b1);

        // Stores: half, byte, and rd+wr with size 11 (word store)
        set_op(0, 1, SZ_HALF, 0, 32'h202, 32'h0000ABCD, 4'd3, 1);
        req_q.push_back('{1'b1, 32'h200, 4'b1100, 32'hABCDABCD});
        run_mem(2, 32'h0, 3, 1'b0);
        set_op(0, 1, SZ_BYTE, 0, 32'h301, 32'h12345677, 4'd3, 1);
        req_q.push_back('{1'b1, 32'h300, 4'b0010, 32'h77777777});
        run_mem(0, 32'h0, 1, 1'b0);
        set_op(1, 1, 2'b11, 0, 32'h404, 32'hCAFEF00D, 4'd4, 1);
        req_q.push_back('{1'b1, 32'h404, 4'b1111, 32'hCAFEF00D});
        run_mem(1, 32'h0, 2, 1'b0);

        // Misaligned word load and misaligned half store
        for (int i = 0; i < 2; i++) begin
            if (i == 0) set_op(1, 0, SZ_WORD, 0, 32'h101, 0, 4'd4, 1);
            else        set_op(0, 1, SZ_HALF, 0, 32'h203, 32'h5555, 4'd4, 1);
            mis_pending++;
            @(negedge clk);
            chk("misalign_nostall", {31'd0, mem_stall}, 32'd0);
            chk("misalign_noreq",   {31'd0, dm_req}, 32'd0);
            @(posedge clk); #1; bubble();
            @(negedge clk);
            chk("misalign_nowb", {31'd0, wb_reg_wr}, 32'd0);
            chk("misalign_noreq2", {31'd0, dm_req}, 32'd0);
            @(negedge clk);
            chk("misalign_width", {31'd0, misalign}, 32'd0);
        end

        // Non-memory pass-through
        set_op(0, 0, SZ_WORD, 0, 32'h000055AA, 0, 4'd9, 1);
        wb_q.push_back('{32'h000055AA, 4'd9});
        @(negedge clk); chk("alu_nostall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1; bubble();
        @(negedge clk); chk("alu_wb_wr", {31'd0, wb_reg_wr}, 32'd1);

        // Flushed non-memory op writes nothing
        set_op(0, 0, SZ_WORD, 0, 32'h77, 0, 4'd10, 1);
        flush = 1'b1;
        @(posedge clk); #1; bubble();
        @(negedge clk); chk("flush_idle_wb", {31'd0, wb_reg_wr}, 32'd0);

        // Flush one cycle into WAIT, ack two cycles later
        set_op(1, 0, SZ_WORD, 0, 32'h400, 0, 4'd11, 1);
        req_q.push_back('{1'b0, 32'h400, 4'b1111, 32'h0});
        @(negedge clk); chk("fl_stall0", {31'd0, mem_stall}, 32'd1);
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk); chk("fl_wait", {30'd0, dm_req, mem_stall}, 32'd3);
        @(posedge clk); #1; bubble();
        @(negedge clk); chk("fl_drain", {30'd0, dm_req, mem_stall}, 32'd3);
        @(posedge clk); #1; dm_ack = 1'b1; dm_rdata = 32'h11111111;
        @(negedge clk); chk("fl_drain_ack", {30'd0, dm_req, mem_stall}, 32'd3);
        @(posedge clk); #1; dm_ack = 1'b0;
        @(negedge clk); chk("fl_done", {29'd0, dm_req, mem_stall, wb_reg_wr}, 32'd0);

        // Next op after the drain proceeds normally
        set_op(1, 0, SZ_WORD, 0, 32'h500, 0, 4'd12, 1);
        req_q.push_back('{1'b0, 32'h500, 4'b1111, 32'h0});
        wb_q.push_back('{32'h0BADF00D, 4'd12});
        run_mem(1, 32'h0BADF00D, 2, 1'b1);

        // Flush with same-cycle ack: completes but no writeback
        set_op(1, 0, SZ_WORD, 0, 32'h600, 0, 4'd13, 1);
        req_q.push_back('{1'b0, 32'h600, 4'b1111, 32'h0});
        @(negedge clk);
        @(posedge clk); #1; flush = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h12345678;
        @(negedge clk); chk("flack_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1; dm_ack = 1'b0; bubble();
        @(negedge clk); chk("flack_wb", {30'd0, dm_req, wb_reg_wr}, 32'd0);

        // Reset while WAIT is outstanding
        set_op(1, 0, SZ_WORD, 0, 32'h700, 0, 4'd14, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("rst_pre_req", {31'd0, dm_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {20'd0, dm_req, dm_we, dm_be, wb_reg_dst, wb_reg_wr, misalign, mem_err, mem_stall}, 32'd0);
        chk("rst_mid_data", dm_addr | dm_wdata | wb_data, 32'd0);
        bubble();
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_replay", {31'd0, dm_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // No ack: request must drop after 64 outstanding cycles
        set_op(1, 0, SZ_WORD, 0, 32'h800, 0, 4'd15, 1);
        @(posedge clk); #1; bubble();
        cnt = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!dm_req) break;
            cnt++;
        end
        chk("timeout_len", cnt - 1, 32'd64);
        chk("timeout_err", {31'd0, mem_err}, 32'd1);
        @(negedge clk);
        chk("timeout_err_width", {30'd0, mem_err, dm_req}, 32'd0);
`else
        cnt = 0;
        chk("mem_err_off", {31'd0, mem_err}, 32'(cnt));
`endif

        repeat (2) @(negedge clk);
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("wb_q_empty",  wb_q.size(), 32'd0);
        chk("mis_pending", mis_pending, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
`default_nettype wire
